fx_requant_pipe: RTL and testbench
==================================

// Module: fx_requant_pipe
// PURPOSE
//  Output stage placed directly after the y = x^2 + x datapath. Takes the datapath's wide
//  signed fixed-point result Q(WI_IN).(WF_IN) and requantises it to a narrower Q(WI_OUT).(WF_OUT).
//  Rounding mode is selectable; results saturate to the output range.
//  Two-stage pipeline with valid/ready flow control, plus saturation statistics for system debug.
// PARAMETERS
//  WI_IN      17  integer bits of input (matches datapath output for 8.8 input)
//  WF_IN      16  fractional bits of input
//  WI_OUT      8  integer bits of output (incl. sign)
//  WF_OUT      8  fractional bits of output; must satisfy WF_OUT <= WF_IN
//  ROUND_MODE  1  0 = truncate (floor), 1 = round half up, 2 = convergent (ties to even)
//  CNT_W      16  width of saturation event counter
// PORTS
//  CLK        in   1                clock, rising edge
//  RST_N      in   1                asynchronous, active-low reset
//  IN_VALID   in   1                input sample valid
//  IN_READY   out  1                stage can accept a sample this cycle
//  X          in   WI_IN+WF_IN      signed input sample
//  OUT_VALID  out  1                Y holds a valid result
//  OUT_READY  in   1                consumer accepts Y this cycle
//  Y          out  WI_OUT+WF_OUT    signed requantised result
//  SAT_FLAG   out  1                Y currently presented was saturated
//  OVF        out  1                sticky: any saturation since last clear
//  SAT_CNT    out  CNT_W            number of saturated samples; holds at all-ones
//  CLR_STAT   in   1                sync clear of OVF and SAT_CNT
// BEHAVIOUR
//  Reset (RST_N=0, async): all valids=0, Y=0, SAT_FLAG=0, OVF=0, SAT_CNT=0; IN_READY=1 after release.
//  Transfer occurs on any edge with VALID && READY on that interface.
//  Pipeline: S1 = round, S2 = saturate/output register. Latency 2 cycles, input accept -> OUT_VALID.
//  Flow control:
//   - adv2 = !S2.v || OUT_READY; adv1 = !S1.v || adv2; IN_READY = adv1 (combinational from OUT_READY).
//   - Full throughput (1 sample/cycle) while OUT_READY=1. No sample is dropped or duplicated.
//   - A stalled stage holds its data and valid unchanged.
//  Rounding in S1, with D = WF_IN - WF_OUT:
//   - Sign-extend X by 1 bit.
//   - Mode 1: add 2^(D-1), then arithmetic shift right by D.
//   - Mode 2: as mode 1, except exact ties (dropped bits == 100..0) round to the even result.
//   - Mode 0 and D=0: shift only.
//  Saturation in S2:
//   - Clamp to [-2^(WI_OUT+WF_OUT-1), 2^(WI_OUT+WF_OUT-1)-1].
//   - SAT_FLAG is registered with Y.
//  Statistics:
//   - SAT_CNT increments and OVF sets only on the cycle a saturated sample enters S2.
//   - CLR_STAT wins over a same-cycle increment: the result is 0 / OVF=0.
//   - SAT_CNT saturates and never wraps.
//  Reset mid-stream discards in-flight samples immediately; no partial output.
// STRUCTURE
//  Shared package fx_pkg:
//   - ROUND_TRUNC=0, ROUND_HALF_UP=1, ROUND_CONV=2.
//   - Functions fx_max/fx_min(width) for saturation limits.
//  Sub-module fx_round_sat: combinational round+clamp, reused by adder/multiplier stages;
//  this block registers around it.
//  Elaboration check: error if WF_OUT > WF_IN or ROUND_MODE > 2.
// TESTING (defaults: Q17.16 -> Q8.8)
//  1. X=0x0_0018000 (1.5), OUT_READY=1 -> Y=0x0180 two cycles after accept, SAT_FLAG=0.
//  2. X=0x80 (half output LSB):
//     mode1 -> Y=0x0001; mode0 -> 0x0000; mode2 -> 0x0000.
//     X=0x180, mode2 -> 0x0002.
//  3. X=200.0 (0x0C80000) -> Y=0x7FFF, SAT_FLAG=1, OVF=1, SAT_CNT=1.
//     X=-200.0 -> Y=0x8000, SAT_CNT=2.
//     CLR_STAT pulse -> OVF=0, SAT_CNT=0.
//  4. Stream 6 samples back-to-back, OUT_READY=0 for cycles 2..4:
//     IN_READY drops after 2 buffered, all 6 outputs in order, none lost.
//  5. RST_N pulled low with 2 samples in flight -> OUT_VALID=0 and Y=0 immediately, no output after release.
//  6. Random 10k samples, random OUT_READY -> compare against reference model (round+clamp), order and count.

Source files
------------

// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared fixed-point constants and saturation limit helpers
// Purpose: rounding mode encodings and signed range limits used by the
//          requantisation datapath and its combinational round/clamp core.
package fx_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;
   localparam int ROUND_CONV    = 2;

   // Largest value representable in a signed two's-complement field of 'width' bits.
   function automatic longint fx_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   // Smallest value representable in a signed two's-complement field of 'width' bits.
   function automatic longint fx_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/fx_round_sat.sv
// rtl/fx_round_sat.sv - combinational fixed-point round and clamp core
// Purpose: rounding half (x -> r) and saturation half (r_in -> y, sat) kept as
//          separate paths so a caller can place a register between them.
// Ports:
//   x     in   WIN       signed input, WF_IN fractional bits
//   r     out  WIN+1     x rounded to WF_OUT fractional bits (one guard bit)
//   r_in  in   WIN+1     rounded value to be clamped
//   y     out  WOUT      r_in clamped to the signed WOUT-bit range
//   sat   out  1         r_in was outside the output range
module fx_round_sat import fx_pkg::*; #(
   parameter int WIN        = 33,
   parameter int WF_IN      = 16,
   parameter int WF_OUT     = 8,
   parameter int WOUT       = 16,
   parameter int ROUND_MODE = ROUND_HALF_UP
) (
   input  logic [WIN-1:0]  x,
   output logic [WIN:0]    r,
   input  logic [WIN:0]    r_in,
   output logic [WOUT-1:0] y,
   output logic            sat
);

   localparam int D  = WF_IN - WF_OUT;
   localparam int RW = WIN + 1;

   // The guard bit keeps x + 2^(D-1) from overflowing at the top of the range.
   logic signed [RW-1:0] xe;
   logic signed [RW-1:0] fl;

   assign xe = $signed({x[WIN-1], x});
   assign fl = xe >>> D;

   generate
      if (D == 0 || ROUND_MODE == ROUND_TRUNC) begin : g_trunc
         assign r = fl;
      end else begin : g_round
         localparam logic [D-1:0] HALF = D'(1) << (D - 1);
         logic [D-1:0] frac;
         logic         up;

         assign frac = x[D-1:0];

         // Adding half then flooring equals flooring then incrementing when the
         // dropped bits are at least half; convergent mode only increments an
         // exact tie when the floored result is odd.
         always_comb begin
            up = 1'b0;
            case (ROUND_MODE)
               ROUND_CONV: up = (frac > HALF) || ((frac == HALF) && fl[0]);
               default:    up = (frac >= HALF);
            endcase
         end

         assign r = fl + {{(RW-1){1'b0}}, up};
      end
   endgenerate

   localparam logic signed [RW-1:0] MAXR = RW'(fx_max(WOUT));
   localparam logic signed [RW-1:0] MINR = RW'(fx_min(WOUT));

   logic signed [RW-1:0] rs;
   assign rs = r_in;

   always_comb begin
      y   = rs[WOUT-1:0];
      sat = 1'b0;
      if (rs > MAXR) begin
         y   = MAXR[WOUT-1:0];
         sat = 1'b1;
      end else if (rs < MINR) begin
         y   = MINR[WOUT-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/fx_requant_pipe.sv
// rtl/fx_requant_pipe.sv - two-stage requantiser with valid/ready flow control
// Purpose: requantise signed Q(WI_IN).(WF_IN) to Q(WI_OUT).(WF_OUT); stage 1
//          rounds, stage 2 saturates and registers the output; keeps
//          saturation statistics for debug.
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   IN_VALID / IN_READY   input handshake, X is the signed input sample
//   OUT_VALID / OUT_READY output handshake, Y is the signed result
//   SAT_FLAG              the presented Y was saturated
//   OVF                   sticky saturation indicator
//   SAT_CNT               saturated sample count, holds at all-ones
//   CLR_STAT              synchronous clear of OVF and SAT_CNT
module fx_requant_pipe import fx_pkg::*; #(
   parameter int WI_IN      = 17,
   parameter int WF_IN      = 16,
   parameter int WI_OUT     = 8,
   parameter int WF_OUT     = 8,
   parameter int ROUND_MODE = ROUND_HALF_UP,
   parameter int CNT_W      = 16
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [WI_IN+WF_IN-1:0]   X,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [WI_OUT+WF_OUT-1:0] Y,
   output logic                     SAT_FLAG,
   output logic                     OVF,
   output logic [CNT_W-1:0]         SAT_CNT,
   input  logic                     CLR_STAT
);

   localparam int WIN  = WI_IN + WF_IN;
   localparam int RW   = WIN + 1;
   localparam int WOUT = WI_OUT + WF_OUT;

   generate
      if (WF_OUT > WF_IN || ROUND_MODE > 2) begin : g_bad_params
         $error("fx_requant_pipe: WF_OUT must not exceed WF_IN and ROUND_MODE must be 0..2");
      end
   endgenerate

   logic            s1_v;
   logic [RW-1:0]   s1_r;
   logic [RW-1:0]   r_c;
   logic [WOUT-1:0] y_c;
   logic            sat_c;
   logic            adv1;
   logic            adv2;
   logic            sat_enter;

   fx_round_sat #(
      .WIN        (WIN),
      .WF_IN      (WF_IN),
      .WF_OUT     (WF_OUT),
      .WOUT       (WOUT),
      .ROUND_MODE (ROUND_MODE)
   ) u_round_sat (
      .x    (X),
      .r    (r_c),
      .r_in (s1_r),
      .y    (y_c),
      .sat  (sat_c)
   );

   // A stage may load when it is empty or its contents move on this edge.
   assign adv2      = !OUT_VALID || OUT_READY;
   assign adv1      = !s1_v || adv2;
   assign IN_READY  = adv1;
   assign sat_enter = adv2 && s1_v && sat_c;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_v <= 1'b0;
         s1_r <= '0;
      end else if (adv1) begin
         s1_v <= IN_VALID;
         if (IN_VALID) begin
            s1_r <= r_c;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OUT_VALID <= 1'b0;
         Y         <= '0;
         SAT_FLAG  <= 1'b0;
      end else if (adv2) begin
         OUT_VALID <= s1_v;
         if (s1_v) begin
            Y        <= y_c;
            SAT_FLAG <= sat_c;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OVF     <= 1'b0;
         SAT_CNT <= '0;
      end else if (CLR_STAT) begin
         OVF     <= 1'b0;
         SAT_CNT <= '0;
      end else if (sat_enter) begin
         OVF <= 1'b1;
         if (SAT_CNT != {CNT_W{1'b1}}) begin
            SAT_CNT <= SAT_CNT + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fx_requant_pipe.sv
// tb/tb_fx_requant_pipe.sv - scoreboard bench for fx_requant_pipe in all three rounding modes
module tb_fx_requant_pipe;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        OUT_READY = 1'b1;
   logic        CLR_STAT = 1'b0;
   logic [32:0] X = '0;

   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic [15:0] y0, y1, y2;
   logic        sf0, sf1, sf2;
   logic        ovf0, ovf1, ovf2;
   logic [3:0]  cnt0;
   logic [15:0] cnt1, cnt2;

   always #5 CLK = ~CLK;

   fx_requant_pipe #(.ROUND_MODE(1)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir1), .X(X),
      .OUT_VALID(ov1), .OUT_READY(OUT_READY), .Y(y1), .SAT_FLAG(sf1),
      .OVF(ovf1), .SAT_CNT(cnt1), .CLR_STAT(CLR_STAT));

   fx_requant_pipe #(.ROUND_MODE(0), .CNT_W(4)) u_m0 (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir0), .X(X),
      .OUT_VALID(ov0), .OUT_READY(OUT_READY), .Y(y0), .SAT_FLAG(sf0),
      .OVF(ovf0), .SAT_CNT(cnt0), .CLR_STAT(CLR_STAT));

   fx_requant_pipe #(.ROUND_MODE(2)) u_m2 (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir2), .X(X),
      .OUT_VALID(ov2), .OUT_READY(OUT_READY), .Y(y2), .SAT_FLAG(sf2),
      .OVF(ovf2), .SAT_CNT(cnt2), .CLR_STAT(CLR_STAT));

   typedef struct packed {
      logic [15:0] e0, e1, e2;
      logic        s0, s1, s2;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   nsat0 = 0, nsat1 = 0, nsat2 = 0;
   int   rdy_mode = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Value-level reference: floor(v / 256) plus a rounding increment, then clamp to Q8.8.
   function automatic void ref_q(input logic [32:0] x, input int mode,
                                 output logic [15:0] y, output logic s);
      longint v, fl, fr, r;
      v  = longint'($signed(x));
      fl = v >>> 8;
      fr = v - fl * 256;
      r  = fl;
      if (mode == 1 && fr >= 128) r = r + 1;
      if (mode == 2 && (fr > 128 || (fr == 128 && (r % 2) != 0))) r = r + 1;
      s = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s = 1'b1;
      end
      y = r[15:0];
   endfunction

   function automatic exp_t model(input logic [32:0] x);
      exp_t e;
      ref_q(x, 0, e.e0, e.s0);
      ref_q(x, 1, e.e1, e.s1);
      ref_q(x, 2, e.e2, e.s2);
      return e;
   endfunction

   function automatic exp_t mk(input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] a2, input logic s);
      exp_t e;
      e.e0 = a0; e.e1 = a1; e.e2 = a2;
      e.s0 = s;  e.s1 = s;  e.s2 = s;
      return e;
   endfunction

   task automatic send(input logic [32:0] x, input exp_t e);
      bit ok;
      ok = 1'b0;
      IN_VALID = 1'b1;
      X = x;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge CLK);
         if (ir1) begin
            ok = 1'b1;
            sb.push_back(e);
            nsat0 += int'(e.s0);
            nsat1 += int'(e.s1);
            nsat2 += int'(e.s2);
         end
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
      if (!ok) chk("send_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic send_rand(input logic [32:0] x);
      send(x, model(x));
   endtask

   function automatic logic [32:0] rand_x();
      logic [63:0] w;
      logic [23:0] s;
      longint      v;
      logic [32:0] x;
      case ($urandom % 4)
         0: begin
            w = {$urandom, $urandom};
            x = w[32:0];
         end
         1: begin
            s = 24'($urandom);
            x = {{9{s[23]}}, s};
         end
         2: begin
            s = 24'($urandom);
            x = {{9{s[23]}}, s[23:8], 8'h80};
         end
         default: begin
            v = (($urandom % 2) != 0) ? longint'(32767 * 256) : longint'(-32768 * 256);
            v = v + longint'($urandom_range(0, 1023)) - 512;
            x = v[32:0];
         end
      endcase
      return x;
   endfunction

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge CLK);
      #1;
      chk("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   task automatic clr_pulse();
      CLR_STAT = 1'b1;
      @(posedge CLK);
      #1;
      CLR_STAT = 1'b0;
      nsat0 = 0; nsat1 = 0; nsat2 = 0;
   endtask

   // Output monitor: a transfer happens on the next rising edge when valid and ready are both high.
   always @(negedge CLK) begin
      exp_t e;
      if (RST_N && ov1) begin
         chk("valid_match", {62'd0, ov0, ov2}, 64'(3));
         if (OUT_READY) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got Y=0x%0h expected no output at %0t", y1, $time);
            end else begin
               e = sb.pop_front();
               chk("y_mode1", 64'(y1), 64'(e.e1));
               chk("sat_mode1", 64'(sf1), 64'(e.s1));
               chk("y_mode0", 64'(y0), 64'(e.e0));
               chk("sat_mode0", 64'(sf0), 64'(e.s0));
               chk("y_mode2", 64'(y2), 64'(e.e2));
               chk("sat_mode2", 64'(sf2), 64'(e.s2));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (rdy_mode == 0) OUT_READY = 1'b1;
         else if (rdy_mode == 1) OUT_READY = (($urandom % 4) != 0);
      end
   end

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int stall_seen;
      logic [32:0] neg200;

      // Reset state
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_out_valid", 64'(ov1), 64'(0));
      RST_N = 1'b1;
      #1;
      chk("rst_in_ready", 64'(ir1), 64'(1));
      chk("rst_y", 64'(y1), 64'(0));
      chk("rst_sat_flag", 64'(sf1), 64'(0));
      chk("rst_ovf", 64'(ovf1), 64'(0));
      chk("rst_sat_cnt", 64'(cnt1), 64'(0));
      @(posedge CLK);
      #1;

      // 1.5 passes through unchanged; valid appears after the second register stage
      send(33'h0_0001_8000, mk(16'h0180, 16'h0180, 16'h0180, 1'b0));
      chk("latency_stage1", 64'(ov1), 64'(0));
      @(posedge CLK);
      #1;
      chk("latency_stage2", 64'(ov1), 64'(1));
      chk("latency_y", 64'(y1), 64'(16'h0180));
      drain();

      // Rounding ties and just-above/below ties
      send(33'h0_0000_0080, mk(16'h0000, 16'h0001, 16'h0000, 1'b0));
      send(33'h0_0000_0180, mk(16'h0001, 16'h0002, 16'h0002, 1'b0));
      send(33'h0_0000_0280, mk(16'h0002, 16'h0003, 16'h0002, 1'b0));
      send(33'h1_FFFF_FF80, mk(16'hFFFF, 16'h0000, 16'h0000, 1'b0));
      send(33'h0_0000_0081, mk(16'h0000, 16'h0001, 16'h0001, 1'b0));
      send(33'h0_0000_007F, mk(16'h0000, 16'h0000, 16'h0000, 1'b0));
      drain();

      // Saturation and statistics
      send(33'h0_00C8_0000, mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1));
      drain();
      chk("sat_pos_flag", 64'(sf1), 64'(1));
      chk("sat_pos_ovf", 64'(ovf1), 64'(1));
      chk("sat_pos_cnt", 64'(cnt1), 64'(1));
      neg200 = 33'h1_FF38_0000;
      send(neg200, mk(16'h8000, 16'h8000, 16'h8000, 1'b1));
      drain();
      chk("sat_neg_cnt", 64'(cnt1), 64'(2));
      chk("sat_neg_cnt_m0", 64'(cnt0), 64'(2));
      chk("sat_neg_cnt_m2", 64'(cnt2), 64'(2));
      clr_pulse();
      chk("clr_ovf", 64'(ovf1), 64'(0));
      chk("clr_cnt", 64'(cnt1), 64'(0));

      // Clear coinciding with a saturated sample entering the output stage
      send(33'h0_00C8_0000, mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1));
      clr_pulse();
      chk("clr_wins_valid", 64'(ov1), 64'(1));
      chk("clr_wins_ovf", 64'(ovf1), 64'(0));
      chk("clr_wins_cnt", 64'(cnt1), 64'(0));
      drain();

      // Back-to-back stream with the consumer stalled for three cycles
      rdy_mode = 2;
      OUT_READY = 1'b1;
      stall_seen = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send_rand(rand_x());
         end
         begin
            for (int c = 0; c < 12; c++) begin
               OUT_READY = !(c >= 2 && c <= 4);
               @(negedge CLK);
               if (!ir1) stall_seen++;
               @(posedge CLK);
               #1;
            end
         end
      join
      chk("stall_in_ready_cycles", 64'(stall_seen), 64'(3));
      rdy_mode = 0;
      drain();

      // Reset with two samples in flight
      rdy_mode = 2;
      OUT_READY = 1'b0;
      send_rand(rand_x());
      send_rand(rand_x());
      #2;
      chk("inflight_valid", 64'(ov1), 64'(1));
      RST_N = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(ov1), 64'(0));
      chk("midrst_y", 64'(y1), 64'(0));
      sb.delete();
      nsat0 = 0; nsat1 = 0; nsat2 = 0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      rdy_mode = 0;
      repeat (6) @(posedge CLK);
      #1;
      chk("midrst_no_output", 64'(ov1), 64'(0));
      chk("midrst_in_ready", 64'(ir1), 64'(1));

      // Randomised stream with random consumer back-pressure
      clr_pulse();
      rdy_mode = 1;
      for (int n = 0; n < 10000; n++) begin
         if (($urandom % 4) == 0) begin
            @(posedge CLK);
            #1;
         end
         send_rand(rand_x());
      end
      rdy_mode = 0;
      drain();
      chk("rand_cnt_m1", 64'(cnt1), 64'((nsat1 > 65535) ? 65535 : nsat1));
      chk("rand_cnt_m0_holds", 64'(cnt0), 64'((nsat0 > 15) ? 15 : nsat0));
      chk("rand_cnt_m2", 64'(cnt2), 64'((nsat2 > 65535) ? 65535 : nsat2));
      chk("rand_ovf_m1", 64'(ovf1), 64'(nsat1 > 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
